regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter REG_AW, default 5, register address width (2**REG_AW registers).
REQ-003 SHALL have port clock  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports wb0_valid/wb1_valid  input  1  writeback request, requester 0 (ALU) / 1 (load unit).
REQ-006 SHALL have ports wb0_rd/wb1_rd  input  REG_AW  destination register.
REQ-007 SHALL have ports wb0_data/wb1_data  input  DATA_W  writeback data.
REQ-008 SHALL have ports wb0_ready/wb1_ready  output  1  grant; a request transfers when valid&&ready.
REQ-009 SHALL have ports issue_valid  input  1, issue_rd  input  REG_AW: an instruction issued with a pending write to issue_rd.
REQ-010 SHALL have ports rs1/rs2  input  REG_AW, and rs1_busy/rs2_busy  output  1: operand has a pending write.
REQ-011 SHALL have ports regwrite  output  1, write_reg  output  REG_AW, write_data  output  DATA_W: register file write port.
REQ-012 SHALL have port err_spurious  output  1  sticky flag: a writeback targeted a non-busy register.

Function
REQ-013 SHALL grant at most one requester per cycle; wbN_ready combinational from valids and the priority pointer.
REQ-014 SHALL arbitrate round-robin: if both valid, grant the pointed-to requester; after any grant, the pointer moves to the other requester.
REQ-015 SHALL grant a single valid requester regardless of pointer; with no valid request, the pointer holds.
REQ-016 SHALL register the granted rd/data onto write_reg/write_data with regwrite=1 the cycle after the handshake (1-cycle latency).
REQ-017 SHALL drive regwrite=0 when no grant occurred or granted rd==0 (the handshake still completes).
REQ-018 SHALL keep a busy bit per register; issue_valid with issue_rd!=0 sets busy[issue_rd] at the clock edge; rd==0 is never busy.
REQ-019 SHALL clear busy[write_reg] on the edge where regwrite=1, unless the same edge sets it; set wins.
REQ-020 SHALL compute rsN_busy = busy[rsN] combinationally; rsN==0 always reports 0.
REQ-021 SHALL set err_spurious when a granted rd!=0 has busy[rd]==0 at grant time, holding it until reset.
REQ-022 SHALL keep a request held by an ungranted requester unchanged; requesters keep valid, rd and data stable until ready.

Reset
REQ-023 SHALL, on reset, clear all busy bits, regwrite, write_reg, write_data and err_spurious to 0 and point the pointer at requester 0.
REQ-024 SHALL drop an in-flight registered write when reset asserts mid-operation (not replayed).
REQ-025 SHALL keep wbN_ready low while reset is asserted.

Configuration
REQ-026 SHALL, with WB_BYPASS_EN defined, add outputs rs1_fwd_valid/rs2_fwd_valid (1) and rs1_fwd_data/rs2_fwd_data (DATA_W).
REQ-027 SHALL, with WB_BYPASS_EN, assert rsN_fwd_valid with rsN_fwd_data=write_data and force rsN_busy=0 when regwrite=1 and write_reg==rsN!=0.
REQ-028 SHALL, without WB_BYPASS_EN, omit the forwarding ports; rsN_busy stays high until the clearing edge.

Structure
REQ-029 SHALL take DATA_W/REG_AW defaults and the requester-index constants (REQ_ALU=0, REQ_LSU=1) from shared package rv_core_pkg.
REQ-030 SHALL implement arbitration in sub-module rr_arb2 (two requesters, pointer, grants); scoreboard and output stage stay in the top.

Verification
REQ-031 SHALL test: reset, issue rd=5, wb0 rd=5 data=0xDEADBEEF -> next cycle regwrite=1, write_reg=5, write_data=0xDEADBEEF; busy[5] clear after that edge.
REQ-032 SHALL test: wb0 and wb1 valid three cycles -> grants 0,1,0; each holder's data appears on write_data in grant order.
REQ-033 SHALL test: wb1 rd=0 data=0x1234 -> wb1_ready=1, regwrite stays 0, err_spurious stays 0.
REQ-034 SHALL test: issue rd=7 on the same edge regwrite=1 write_reg=7 -> rs1=7 reports busy=1 next cycle.
REQ-035 SHALL test: wb0 rd=9 with busy[9]=0 -> err_spurious=1, still 1 after ten idle cycles.
REQ-036 SHALL test with WB_BYPASS_EN: rs2=3, regwrite=1 write_reg=3 write_data=0xA5A5A5A5 -> rs2_fwd_valid=1, rs2_fwd_data=0xA5A5A5A5, rs2_busy=0.

Source files
------------

// File: rtl/rv_core_pkg.sv
// Shared core constants for the writeback path: default register-file
// geometry, requester indices, and a small helper for the round-robin pointer.
package rv_core_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int REG_AW_DEFAULT = 5;

  // Requester 0 is the ALU writeback, requester 1 the load unit
  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  // The requester that gets priority after idx has been served
  function automatic logic other_req(input logic idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. A lone requester always wins; on a tie the
// pointer decides, and every grant hands priority to the other requester.
// Grants are forced low while reset is asserted.
module rr_arb2
  import rv_core_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       grant_idx,
  output logic       grant_any
);

  logic ptr;

  // Pick the winner from the valids and the priority pointer
  always_comb begin
    grant     = 2'b00;
    grant_idx = REQ_ALU;
    grant_any = 1'b0;
    if (!reset) begin
      if (valid[0] && valid[1]) begin
        grant_idx = ptr;
      end else if (valid[1]) begin
        grant_idx = REQ_LSU;
      end else begin
        grant_idx = REQ_ALU;
      end
      grant_any = valid[0] || valid[1];
      if (grant_any) begin
        grant = (grant_idx == REQ_LSU) ? 2'b10 : 2'b01;
      end
    end
  end

  // Pass priority to the loser after each grant; hold when idle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= REQ_ALU;
    end else if (grant_any) begin
      ptr <= other_req(grant_idx);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter in front of the register file write port. Two writeback
// sources (ALU, load unit) are arbitrated round-robin, the winner is
// registered onto the write port one cycle later, and a per-register busy
// scoreboard tracks destinations with writes still outstanding.
// Optional feature: define WB_BYPASS_EN to add operand forwarding from the
// registered write port, which also hides the busy bit of the register
// being written that cycle.
module regfile_wb_arbiter
  import rv_core_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wb0_valid,
  input  logic [REG_AW-1:0] wb0_rd,
  input  logic [DATA_W-1:0] wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [REG_AW-1:0] wb1_rd,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb1_ready,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              regwrite,
  output logic [REG_AW-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              err_spurious
`ifdef WB_BYPASS_EN
  ,
  output logic              rs1_fwd_valid,
  output logic [DATA_W-1:0] rs1_fwd_data,
  output logic              rs2_fwd_valid,
  output logic [DATA_W-1:0] rs2_fwd_data
`endif
);

  localparam int NREG = 2 ** REG_AW;

  logic [1:0]        grant;
  logic              grant_idx;
  logic              grant_any;
  logic [REG_AW-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_next;

  rr_arb2 u_arb (
    .clock     (clock),
    .reset     (reset),
    .valid     ({wb1_valid, wb0_valid}),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign wb0_ready = grant[0];
  assign wb1_ready = grant[1];

  // Route the winning request's destination and data to the output stage
  always_comb begin
    sel_rd   = wb0_rd;
    sel_data = wb0_data;
    if (grant_idx == REQ_LSU) begin
      sel_rd   = wb1_rd;
      sel_data = wb1_data;
    end
  end

  // Register the granted write; rd 0 completes the handshake but writes nothing
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regwrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      regwrite <= grant_any && (sel_rd != '0);
      if (grant_any) begin
        write_reg  <= sel_rd;
        write_data <= sel_data;
      end
    end
  end

  // Scoreboard next state: the write port clears, a new issue sets and wins
  always_comb begin
    busy_next = busy_q;
    if (regwrite) begin
      busy_next[write_reg] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

  // Sticky flag for a writeback to a register nothing was waiting on
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_spurious <= 1'b0;
    end else if (grant_any && (sel_rd != '0) && !busy_q[sel_rd]) begin
      err_spurious <= 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  logic fwd1;
  logic fwd2;

  assign fwd1          = regwrite && (write_reg == rs1) && (rs1 != '0);
  assign fwd2          = regwrite && (write_reg == rs2) && (rs2 != '0);
  assign rs1_fwd_valid = fwd1;
  assign rs2_fwd_valid = fwd2;
  assign rs1_fwd_data  = write_data;
  assign rs2_fwd_data  = write_data;
  assign rs1_busy      = busy_q[rs1] && (rs1 != '0) && !fwd1;
  assign rs2_busy      = busy_q[rs2] && (rs2 != '0) && !fwd2;
`else
  assign rs1_busy = busy_q[rs1] && (rs1 != '0);
  assign rs2_busy = busy_q[rs2] && (rs2 != '0);
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run against a behavioural model of the arbiter and scoreboard.
// Builds with or without WB_BYPASS_EN.
module tb_regfile_wb_arbiter;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  logic          clock;
  logic          reset;
  logic          wb0_valid, wb1_valid;
  logic [AW-1:0] wb0_rd, wb1_rd;
  logic [DW-1:0] wb0_data, wb1_data;
  logic          wb0_ready, wb1_ready;
  logic          issue_valid;
  logic [AW-1:0] issue_rd;
  logic [AW-1:0] rs1, rs2;
  logic          rs1_busy, rs2_busy;
  logic          regwrite;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic          err_spurious;
`ifdef WB_BYPASS_EN
  logic          rs1_fwd_valid, rs2_fwd_valid;
  logic [DW-1:0] rs1_fwd_data, rs2_fwd_data;
`endif

  int tests_run;
  int tests_failed;

  regfile_wb_arbiter #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clock        (clock),
    .reset        (reset),
    .wb0_valid    (wb0_valid),
    .wb0_rd       (wb0_rd),
    .wb0_data     (wb0_data),
    .wb0_ready    (wb0_ready),
    .wb1_valid    (wb1_valid),
    .wb1_rd       (wb1_rd),
    .wb1_data     (wb1_data),
    .wb1_ready    (wb1_ready),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .regwrite     (regwrite),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .err_spurious (err_spurious)
`ifdef WB_BYPASS_EN
    ,
    .rs1_fwd_valid (rs1_fwd_valid),
    .rs1_fwd_data  (rs1_fwd_data),
    .rs2_fwd_valid (rs2_fwd_valid),
    .rs2_fwd_data  (rs2_fwd_data)
`endif
  );

  // 10-unit free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    wb0_valid   = 1'b0; wb0_rd = '0; wb0_data = '0;
    wb1_valid   = 1'b0; wb1_rd = '0; wb1_data = '0;
    issue_valid = 1'b0; issue_rd = '0;
    rs1 = '0; rs2 = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    wb0_valid = 1'b1; wb0_rd = 5'd1;
    wb1_valid = 1'b1; wb1_rd = 5'd2;
    rs1 = 5'd1;
    tick();
    tick();
    tests_run++;
    if (wb0_ready !== 1'b0 || wb1_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ready: got %b%b, expected 00", wb1_ready, wb0_ready);
    end
    tests_run++;
    if (regwrite !== 1'b0 || write_reg !== '0 || write_data !== '0 || err_spurious !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got rw=%b reg=%0d data=%0h err=%b, expected all 0",
               regwrite, write_reg, write_data, err_spurious);
    end
    tests_run++;
    if (rs1_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_busy: got %b, expected 0", rs1_busy);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (wb0_ready !== 1'b1 || wb1_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_pointer: got %b%b, expected 01", wb1_ready, wb0_ready);
    end
    clear_inputs();
  endtask

  task automatic test_basic_write();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd5;
    tick();
    issue_valid = 1'b0;
    wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'hDEADBEEF;
    rs1 = 5'd5;
    #1;
    tests_run++;
    if (wb0_ready !== 1'b1 || wb1_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_grant: got %b%b, expected 01", wb1_ready, wb0_ready);
    end
    tests_run++;
    if (rs1_busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL basic_busy_set: got %b, expected 1", rs1_busy);
    end
    tick();
    wb0_valid = 1'b0;
    #1;
    tests_run++;
    if (regwrite !== 1'b1 || write_reg !== 5'd5 || write_data !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("[TB] FAIL basic_write: got rw=%b reg=%0d data=%h, expected 1/5/deadbeef",
               regwrite, write_reg, write_data);
    end
    tests_run++;
`ifdef WB_BYPASS_EN
    if (rs1_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_busy_fwd: got %b, expected 0", rs1_busy);
    end
`else
    if (rs1_busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL basic_busy_hold: got %b, expected 1", rs1_busy);
    end
`endif
    tick();
    tests_run++;
    if (rs1_busy !== 1'b0 || regwrite !== 1'b0 || err_spurious !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL basic_clear: got busy=%b rw=%b err=%b, expected 0/0/0",
               rs1_busy, regwrite, err_spurious);
    end
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] exp_data [4];
    logic [AW-1:0] exp_reg  [4];
    logic [1:0]    exp_rdy  [4];
    exp_data = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004};
    exp_reg  = '{5'd1, 5'd2, 5'd3, 5'd4};
    exp_rdy  = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      issue_valid = 1'b1; issue_rd = AW'(r);
      tick();
    end
    issue_valid = 1'b0;
    wb0_valid = 1'b1; wb0_rd = 5'd1; wb0_data = 32'hAAAA0001;
    wb1_valid = 1'b1; wb1_rd = 5'd2; wb1_data = 32'hBBBB0002;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests_run++;
      if ({wb1_ready, wb0_ready} !== exp_rdy[k]) begin
        tests_failed++;
        $display("[TB] FAIL rr_grant%0d: got %b%b, expected %b", k, wb1_ready, wb0_ready, exp_rdy[k]);
      end
      tick();
      if (k == 0) begin
        wb0_rd = 5'd3; wb0_data = 32'hCCCC0003;
      end else if (k == 1) begin
        wb1_rd = 5'd4; wb1_data = 32'hDDDD0004;
      end else if (k == 2) begin
        wb0_valid = 1'b0;
      end else begin
        wb1_valid = 1'b0;
      end
      tests_run++;
      if (regwrite !== 1'b1 || write_reg !== exp_reg[k] || write_data !== exp_data[k]) begin
        tests_failed++;
        $display("[TB] FAIL rr_write%0d: got rw=%b reg=%0d data=%h, expected 1/%0d/%h",
                 k, regwrite, write_reg, write_data, exp_reg[k], exp_data[k]);
      end
    end
    tests_run++;
    if (err_spurious !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rr_err: got %b, expected 0", err_spurious);
    end
  endtask

  task automatic test_rd_zero();
    do_reset();
    wb1_valid = 1'b1; wb1_rd = 5'd0; wb1_data = 32'h00001234;
    #1;
    tests_run++;
    if (wb1_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL rd0_ready: got %b, expected 1", wb1_ready);
    end
    tick();
    wb1_valid = 1'b0;
    tests_run++;
    if (regwrite !== 1'b0 || err_spurious !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rd0_nowrite: got rw=%b err=%b, expected 0/0", regwrite, err_spurious);
    end
  endtask

  task automatic test_set_wins();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    wb0_valid = 1'b1; wb0_rd = 5'd7; wb0_data = 32'h77777777;
    tick();
    wb0_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    rs1 = 5'd7;
    tests_run++;
    if (regwrite !== 1'b1 || write_reg !== 5'd7) begin
      tests_failed++;
      $display("[TB] FAIL setwins_write: got rw=%b reg=%0d, expected 1/7", regwrite, write_reg);
    end
    tick();
    issue_valid = 1'b0;
    #1;
    tests_run++;
    if (rs1_busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL setwins_busy: got %b, expected 1", rs1_busy);
    end
  endtask

  task automatic test_spurious();
    do_reset();
    wb0_valid = 1'b1; wb0_rd = 5'd9; wb0_data = 32'h99999999;
    #1;
    tests_run++;
    if (err_spurious !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL spur_before: got %b, expected 0", err_spurious);
    end
    tick();
    wb0_valid = 1'b0;
    tests_run++;
    if (err_spurious !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL spur_set: got %b, expected 1", err_spurious);
    end
    repeat (10) tick();
    tests_run++;
    if (err_spurious !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL spur_sticky: got %b, expected 1", err_spurious);
    end
  endtask

  task automatic test_midflight_reset();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd6;
    tick();
    issue_valid = 1'b0;
    wb1_valid = 1'b1; wb1_rd = 5'd6; wb1_data = 32'h66666666;
    rs1 = 5'd6;
    tick();
    wb1_valid = 1'b0;
    tests_run++;
    if (regwrite !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midrst_inflight: got %b, expected 1", regwrite);
    end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (regwrite !== 1'b0 || write_data !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_drop: got rw=%b data=%h, expected 0/0", regwrite, write_data);
    end
    tick();
    reset = 1'b0;
    tick();
    tests_run++;
    if (regwrite !== 1'b0 || rs1_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midrst_after: got rw=%b busy=%b, expected 0/0", regwrite, rs1_busy);
    end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    issue_valid = 1'b0;
    wb1_valid = 1'b1; wb1_rd = 5'd3; wb1_data = 32'hA5A5A5A5;
    tick();
    wb1_valid = 1'b0;
    rs2 = 5'd3; rs1 = 5'd0;
    #1;
    tests_run++;
    if (rs2_fwd_valid !== 1'b1 || rs2_fwd_data !== 32'hA5A5A5A5 || rs2_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bypass_rs2: got v=%b d=%h busy=%b, expected 1/a5a5a5a5/0",
               rs2_fwd_valid, rs2_fwd_data, rs2_busy);
    end
    tests_run++;
    if (rs1_fwd_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bypass_rs1_zero: got %b, expected 0", rs1_fwd_valid);
    end
  endtask
`endif

  // Randomized run: requesters hold their request until granted, and the
  // model decides grants, busy state and the error flag from the rules alone.
  task automatic test_random(input int cycles);
    bit            p_valid [2];
    logic [AW-1:0] p_rd    [2];
    logic [DW-1:0] p_data  [2];
    bit            m_busy  [NREG];
    int            last_gnt;
    int            g;
    bit            m_err;
    bit            m_rw;
    int            m_wreg;
    logic [DW-1:0] m_wdata;
    bit            exp_b1, exp_b2;
    int            busy_list [$];
    do_reset();
    for (int k = 0; k < NREG; k++) m_busy[k] = 1'b0;
    p_valid = '{1'b0, 1'b0};
    last_gnt = 1;
    m_err = 1'b0; m_rw = 1'b0; m_wreg = 0; m_wdata = '0;
    for (int c = 0; c < cycles; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!p_valid[r] && $urandom_range(0, 2) != 0) begin
          busy_list.delete();
          for (int k = 1; k < NREG; k++) if (m_busy[k]) busy_list.push_back(k);
          if (busy_list.size() > 0 && $urandom_range(0, 7) != 0)
            p_rd[r] = AW'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
          else
            p_rd[r] = AW'($urandom_range(0, NREG - 1));
          p_data[r]  = $urandom;
          p_valid[r] = 1'b1;
        end
      end
      wb0_valid = p_valid[0]; wb0_rd = p_rd[0]; wb0_data = p_data[0];
      wb1_valid = p_valid[1]; wb1_rd = p_rd[1]; wb1_data = p_data[1];
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = AW'($urandom_range(0, NREG - 1));
      rs1 = AW'($urandom_range(0, NREG - 1));
      rs2 = AW'($urandom_range(0, NREG - 1));
      #1;
      if (p_valid[0] && p_valid[1]) g = 1 - last_gnt;
      else if (p_valid[0]) g = 0;
      else if (p_valid[1]) g = 1;
      else g = -1;
      tests_run++;
      if (wb0_ready !== (g == 0) || wb1_ready !== (g == 1)) begin
        tests_failed++;
        $display("[TB] FAIL rand_grant c%0d: got %b%b, expected grant to %0d", c, wb1_ready, wb0_ready, g);
      end
`ifdef WB_BYPASS_EN
      exp_b1 = m_busy[rs1] && !(m_rw && m_wreg == int'(rs1));
      exp_b2 = m_busy[rs2] && !(m_rw && m_wreg == int'(rs2));
`else
      exp_b1 = m_busy[rs1];
      exp_b2 = m_busy[rs2];
`endif
      tests_run++;
      if (rs1_busy !== exp_b1 || rs2_busy !== exp_b2) begin
        tests_failed++;
        $display("[TB] FAIL rand_busy c%0d: got %b%b, expected %b%b", c, rs1_busy, rs2_busy, exp_b1, exp_b2);
      end
      if (g >= 0 && p_rd[g] != '0 && !m_busy[p_rd[g]]) m_err = 1'b1;
      if (m_rw) m_busy[m_wreg] = 1'b0;
      if (issue_valid && issue_rd != '0) m_busy[issue_rd] = 1'b1;
      if (g >= 0) begin
        m_rw       = (p_rd[g] != '0);
        m_wreg     = int'(p_rd[g]);
        m_wdata    = p_data[g];
        last_gnt   = g;
        p_valid[g] = 1'b0;
      end else begin
        m_rw = 1'b0;
      end
      tick();
      tests_run++;
      if (regwrite !== m_rw || (m_rw && (int'(write_reg) != m_wreg || write_data !== m_wdata))) begin
        tests_failed++;
        $display("[TB] FAIL rand_write c%0d: got rw=%b reg=%0d data=%h, expected %b/%0d/%h",
                 c, regwrite, write_reg, write_data, m_rw, m_wreg, m_wdata);
      end
      tests_run++;
      if (err_spurious !== m_err) begin
        tests_failed++;
        $display("[TB] FAIL rand_err c%0d: got %b, expected %b", c, err_spurious, m_err);
      end
    end
    clear_inputs();
  endtask

  // Run every scenario in order, then report
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    clear_inputs();
    test_reset();
    test_basic_write();
    test_round_robin();
    test_rd_zero();
    test_set_wins();
    test_spurious();
    test_midflight_reset();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    test_random(400);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
